// File: rtl/assoc_cache_pkg.sv
// Shared types and width helpers for the set-associative cache.
// Ports: none (package).
// Holds the controller state enum and the derived-width helpers.
package assoc_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        RESP
    } state_t;

    // Set index width for a power-of-two set count.
    function automatic int idx_width(input int num_sets);
        return $clog2(num_sets);
    endfunction

    // Tag width is whatever address bits remain above the index.
    function automatic int tag_width(input int addr_width, input int num_sets);
        return addr_width - $clog2(num_sets);
    endfunction

    // Way-select width; a direct-mapped cache still carries a 1-bit way number.
    function automatic int way_width(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

endpackage

// File: rtl/assoc_cache_way_sel.sv
// Combinational way selection for one set: hit vector, hit way, first invalid way, victim.
// Ports: valid/tags/rr_ptr of the set and the request tag in; hit info and victim way out.
// Zero latency, no backpressure.
import assoc_cache_pkg::*;

module assoc_cache_way_sel #(
    parameter int NUM_WAYS = 4,
    parameter int TAG_W    = 24,
    parameter int WAY_W    = 2
) (
    input  logic [NUM_WAYS-1:0]       valid,
    input  logic [NUM_WAYS*TAG_W-1:0] tags,
    input  logic [TAG_W-1:0]          req_tag,
    input  logic [WAY_W-1:0]          rr_ptr,
    output logic [NUM_WAYS-1:0]       hit_vec,
    output logic                      hit,
    output logic [WAY_W-1:0]          hit_way,
    output logic [WAY_W-1:0]          first_inv,
    output logic [WAY_W-1:0]          victim
);

    logic any_inv;

    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = valid[w] && (tags[w*TAG_W +: TAG_W] == req_tag);
        end
    end

    // A hit needs exactly one matching way.
    assign hit = $onehot(hit_vec);

    // Scan from the top so the lowest-numbered match/invalid way wins.
    always_comb begin
        hit_way   = '0;
        first_inv = '0;
        any_inv   = 1'b0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
            if (!valid[w]) begin
                first_inv = WAY_W'(w);
                any_inv   = 1'b1;
            end
        end
    end

    assign victim = any_inv ? first_inv : rr_ptr;

endmodule

// File: rtl/assoc_cache.sv
// Set-associative, write-through, no-write-allocate line cache with round-robin replacement.
// Ports: core req/resp handshake, backing-memory req/resp, saturating hit/miss counters.
// Read hit: resp 2 cycles after handshake; misses/writes wait on mem_req_ready (and refill).
import assoc_cache_pkg::*;

module assoc_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int NUM_SETS   = 256,
    parameter int NUM_WAYS   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int IDX_W = idx_width(NUM_SETS);
    localparam int TAG_W = tag_width(ADDR_WIDTH, NUM_SETS);
    localparam int WAY_W = way_width(NUM_WAYS);

    state_t state, state_nxt;

    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  hit_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Valid bits and round-robin pointers are reset; tag/data storage is not.
    logic [NUM_WAYS-1:0]   valid_arr [NUM_SETS];
    logic [WAY_W-1:0]      rr_arr    [NUM_SETS];
    logic [TAG_W-1:0]      tag_arr   [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] data_arr  [NUM_SETS][NUM_WAYS];

    logic [IDX_W-1:0]          idx;
    logic [TAG_W-1:0]          tag;
    logic [NUM_WAYS*TAG_W-1:0] set_tags;
    logic [NUM_WAYS-1:0]       hit_vec;
    logic                      hit;
    logic [WAY_W-1:0]          hit_way;
    logic [WAY_W-1:0]          first_inv;
    logic [WAY_W-1:0]          victim;
    logic [WAY_W-1:0]          rr_nxt;

    assign idx = addr_q[IDX_W-1:0];
    assign tag = addr_q[ADDR_WIDTH-1:IDX_W];

    always_comb begin
        set_tags = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            set_tags[w*TAG_W +: TAG_W] = tag_arr[idx][w];
        end
    end

    assoc_cache_way_sel #(
        .NUM_WAYS (NUM_WAYS),
        .TAG_W    (TAG_W),
        .WAY_W    (WAY_W)
    ) u_way_sel (
        .valid     (valid_arr[idx]),
        .tags      (set_tags),
        .req_tag   (tag),
        .rr_ptr    (rr_arr[idx]),
        .hit_vec   (hit_vec),
        .hit       (hit),
        .hit_way   (hit_way),
        .first_inv (first_inv),
        .victim    (victim)
    );

    assign rr_nxt = (rr_arr[idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_arr[idx] + WAY_W'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req_valid)      state_nxt = LOOKUP;
            LOOKUP:   state_nxt = (write_q || !hit) ? MEM_REQ : RESP;
            MEM_REQ:  if (mem_req_ready)  state_nxt = write_q ? RESP : MEM_WAIT;
            MEM_WAIT: if (mem_resp_valid) state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hit_q      <= 1'b0;
            rdata_q    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_arr[s] <= '0;
                rr_arr[s]    <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                    end
                end
                LOOKUP: begin
                    hit_q   <= hit;
                    rdata_q <= (!write_q && hit) ? data_arr[idx][hit_way] : '0;
                    if (hit) begin
                        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
                    end else begin
                        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_q                <= mem_resp_rdata;
                        valid_arr[idx][victim] <= 1'b1;
                        rr_arr[idx]            <= rr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag/data storage has no reset; an async reset drops the state out of
    // LOOKUP/MEM_WAIT at once, so no write lands from an abandoned transaction.
    always_ff @(posedge clk) begin
        if (state == LOOKUP && write_q && hit) begin
            data_arr[idx][hit_way] <= wdata_q;
        end
        if (state == MEM_WAIT && mem_resp_valid) begin
            tag_arr[idx][victim]  <= tag;
            data_arr[idx][victim] <= mem_resp_rdata;
        end
    end

    assign req_ready     = (state == IDLE);
    assign resp_valid    = (state == RESP);
    assign resp_hit      = (state == RESP) && hit_q;
    assign resp_rdata    = (state == RESP) ? rdata_q : '0;
    assign mem_req_valid = (state == MEM_REQ);
    assign mem_req_write = (state == MEM_REQ) && write_q;
    assign mem_req_addr  = (state == MEM_REQ) ? addr_q : '0;
    assign mem_req_wdata = (state == MEM_REQ && write_q) ? wdata_q : '0;

endmodule
